rom_port_arbiter: RTL
=====================

Name: rom_port_arbiter

Overview:
- Shares the single slow instruction-ROM controller between two requesters: the instruction-fetch port (I) and the data-load port (D, for constants and tables in ROM).
- The ROM controller handshake is: a MemRead request, then DataValid low while busy, then DataValid high again with the read word valid.
- The arbiter grants one requester, sequences that handshake, returns the word with a one-cycle Ack, and flags a watchdog timeout.
- It sits between the CPU fetch/load stages and the ROM controller.

Parameters:
- TIMEOUT_CYC, 16: max cycles spent in WAIT_BUSY plus WAIT_DONE before a transaction aborts. Legal range 2..255. The timeout counter is 8 bits.
- ADDR_W, 32: address width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset_L  in  1  asynchronous active-low reset.
- IReq  in  1  fetch request; held high until IAck.
- IAddr  in  ADDR_W  fetch byte address.
- IAck  out  1  one-cycle pulse; IData is valid in that cycle.
- IData  out  32  fetched word; holds its value between acks.
- DReq  in  1  data-load request; held high until DAck.
- DAddr  in  ADDR_W  load byte address.
- DAck  out  1  one-cycle pulse; DData is valid in that cycle.
- DData  out  32  loaded word; holds its value between acks.
- MemRead  out  1  read strobe to the ROM controller, one cycle wide.
- MemAddr  out  ADDR_W  address to the ROM controller, word aligned.
- MemDataValid  in  1  ROM controller ready/valid: high = idle with data valid, low = busy.
- MemDataIn  in  32  ROM controller read data.
- Busy  out  1  high in every state except IDLE.
- TimeoutErr  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (asynchronous, Reset_L=0): state IDLE, MemRead=0, MemAddr=0, IAck=DAck=0, IData=DData=0, TimeoutErr=0, grant register=I, timeout counter=0. Assertion mid-transaction aborts the transaction immediately with no Ack.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - Transition requires (IReq|DReq) && MemDataValid.
  - Selection is fixed priority, D over I.
  - At that edge: latch grant, latch MemAddr={addr[ADDR_W-1:2],2'b00}, set MemRead=1, go to ISSUE.
- ISSUE:
  - Lasts exactly one cycle with MemRead=1.
  - Next edge: MemRead=0, go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for MemDataValid=0, then go to WAIT_DONE.
- WAIT_DONE:
  - Wait for MemDataValid=1.
  - At that edge: capture MemDataIn into IData or DData according to the grant, pulse the matching Ack, go to RESP.
- RESP:
  - Lasts one cycle; Ack is high during it.
  - Next edge: Ack=0, go to IDLE.
  - A new grant takes at least one IDLE cycle, so the requester's Req is sampled after it has seen Ack.
- Latency: with the controller at 4 wait cycles, Ack rises 8 cycles after the IDLE edge that granted.
- MemAddr stays stable from ISSUE until the next grant.
- Requester drops Req mid-transaction: the transaction still completes, data is written and Ack pulses. The requester ignores it.
- Changes on IAddr/DAddr after grant have no effect.
- Timeout:
  - The counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYC: set TimeoutErr=1, write 32'h0 to the granted data output, pulse its Ack, go to RESP.
  - The timeout takes precedence over a MemDataValid rising edge in the same cycle.
- The losing requester stays pending. It is served after RESP if it is still requesting. Under fixed priority, D starvation of I is permitted.

Optional Feature:
- Macro: ROM_ARB_RR_EN.
- Defined: round-robin arbitration. When both IReq and DReq are high in IDLE, grant the port NOT granted last. After reset the last-granted port is I, so the first tie goes to D.
- Undefined: fixed priority, D over I; the last-grant register is unused and may be optimised away.

Test Plan:
- Reset, then IReq=1, IAddr=32'h0000_0042; controller model with 4 wait cycles returning 32'hDEADBEEF -> MemAddr=32'h0000_0040, a single MemRead pulse, IAck exactly one cycle 8 cycles after grant, IData=32'hDEADBEEF, DAck never asserted.
- IReq and DReq rise in the same cycle (IAddr=0x10, DAddr=0x20), both held high -> D is served first (MemAddr=0x20), then I (MemAddr=0x10), at least one IDLE cycle between them. With ROM_ARB_RR_EN and repeated ties: grants alternate D,I,D,I.
- Controller model holds MemDataValid=1 forever after MemRead, TIMEOUT_CYC=16 -> 16 cycles after entering WAIT_BUSY: IAck pulse, IData=0, TimeoutErr=1 and held; the next request proceeds normally with TimeoutErr still 1.
- Reset_L pulsed low for 1 cycle while in WAIT_DONE -> immediately MemRead=0, no Ack, Busy=0, TimeoutErr=0; a new IReq after release completes normally.
- IReq arrives while MemDataValid=0 (controller busy from a prior reset) -> no MemRead until MemDataValid=1, then normal transaction.
- DReq dropped in WAIT_BUSY and DAddr changed -> DAck still pulses, DData = word for the original address, MemAddr unchanged.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Shares one ROM controller between fetch (I) and load (D) ports; Ack rises 8 cycles after grant with a 4-wait-cycle controller.
// Requests wait in IDLE while MemDataValid is low; fixed D-over-I priority, or round-robin on ties when ROM_ARB_RR_EN is defined.
module rom_port_arbiter #(
  parameter int TIMEOUT_CYC = 16,
  parameter int ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IAck,
  output logic [31:0]       IData,
  input  logic              DReq,
  input  logic [ADDR_W-1:0] DAddr,
  output logic              DAck,
  output logic [31:0]       DData,
  output logic              MemRead,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemDataValid,
  input  logic [31:0]       MemDataIn,
  output logic              Busy,
  output logic              TimeoutErr
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [2:0]  state;
  logic        grant_d;
  logic [7:0]  tmo_cnt;
  logic        pick_d;
  logic        waiting;
  logic        fin_tmo;
  logic        fin_ok;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{IAddr[1:0], DAddr[1:0]};

  // grant_d doubles as the last-granted port for round-robin tie breaking
  always_comb begin
    pick_d = DReq;
`ifdef ROM_ARB_RR_EN
    if (IReq && DReq)
      pick_d = ~grant_d;
`endif
  end

  // Timeout beats a MemDataValid rise in the same cycle
  assign waiting = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
  assign fin_tmo = waiting && (tmo_cnt == TMO_LAST);
  assign fin_ok  = (state == S_WAIT_DONE) && MemDataValid && !fin_tmo;
  assign rd_word = fin_tmo ? 32'h0 : MemDataIn;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state      <= S_IDLE;
      grant_d    <= 1'b0;
      tmo_cnt    <= 8'd0;
      MemRead    <= 1'b0;
      MemAddr    <= '0;
      IAck       <= 1'b0;
      DAck       <= 1'b0;
      IData      <= 32'h0;
      DData      <= 32'h0;
      Busy       <= 1'b0;
      TimeoutErr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((IReq || DReq) && MemDataValid) begin
            grant_d <= pick_d;
            MemAddr <= pick_d ? {DAddr[ADDR_W-1:2], 2'b00} : {IAddr[ADDR_W-1:2], 2'b00};
            MemRead <= 1'b1;
            Busy    <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          MemRead <= 1'b0;
          tmo_cnt <= 8'd0;
          state   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          if (fin_tmo || fin_ok) begin
            if (fin_tmo)
              TimeoutErr <= 1'b1;
            if (grant_d) begin
              DData <= rd_word;
              DAck  <= 1'b1;
            end else begin
              IData <= rd_word;
              IAck  <= 1'b1;
            end
            state <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if ((state == S_WAIT_BUSY) && !MemDataValid)
              state <= S_WAIT_DONE;
          end
        end
        S_RESP: begin
          IAck  <= 1'b0;
          DAck  <= 1'b0;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          MemRead <= 1'b0;
          IAck    <= 1'b0;
          DAck    <= 1'b0;
          Busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
